// File: rtl/pipe_stage_skid_pkg.sv
// Shared constants for the EX/MEM pipeline stage register.
//   - Machine word, register address and control field widths
//   - Packed EX/MEM payload layout: field offsets, struct view and pack/unpack helpers
//   - Skid-stage occupancy states, encoded as {main_valid, skid_valid}
package pipe_stage_skid_pkg;

  localparam int unsigned WORD_SIZE  = 16;
  localparam int unsigned REG_ADDR_W = 2;
  localparam int unsigned CTRL_W     = 5;

  // Payload layout, LSB first: rd | wdata | alu | pc | jump_to_reg | wrong_predict | ctrl
  localparam int unsigned RD_LSB            = 0;
  localparam int unsigned WDATA_LSB         = RD_LSB + REG_ADDR_W;
  localparam int unsigned ALU_LSB           = WDATA_LSB + WORD_SIZE;
  localparam int unsigned PC_LSB            = ALU_LSB + WORD_SIZE;
  localparam int unsigned JUMP_TO_REG_BIT   = PC_LSB + WORD_SIZE;
  localparam int unsigned WRONG_PREDICT_BIT = JUMP_TO_REG_BIT + 1;
  localparam int unsigned CTRL_LSB          = WRONG_PREDICT_BIT + 1;
  localparam int unsigned PIPE_PAYLOAD_W    = CTRL_LSB + CTRL_W;

  // Field order matches the offsets above (first member is the MSB end).
  typedef struct packed {
    logic [CTRL_W-1:0]     ctrl;
    logic                  wrong_predict;
    logic                  jump_to_reg;
    logic [WORD_SIZE-1:0]  pc;
    logic [WORD_SIZE-1:0]  alu;
    logic [WORD_SIZE-1:0]  wdata;
    logic [REG_ADDR_W-1:0] rd;
  } exmem_payload_t;

  // {main_valid, skid_valid}; StIllegal is unreachable and only decoded for recovery.
  typedef enum logic [1:0] {
    StEmpty   = 2'b00,
    StIllegal = 2'b01,
    StOne     = 2'b10,
    StFull    = 2'b11
  } skid_state_e;

  function automatic logic [PIPE_PAYLOAD_W-1:0] exmem_pack(input exmem_payload_t p);
    return p;
  endfunction

  function automatic exmem_payload_t exmem_unpack(input logic [PIPE_PAYLOAD_W-1:0] v);
    return exmem_payload_t'(v);
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with enable.
//   Clk, Reset_N (sync, active-low) | en : count this cycle | cnt : current count
// Sticks at all-ones once reached; only reset clears it.
module pipe_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         Clk,
  input  logic         Reset_N,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
//   Clk, Reset_N (sync, active-low)
//   flush              : drop all held entries and any entry offered this cycle
//   in_valid/in_ready  : upstream handshake; in_ready is a flop (= !skid_valid)
//   in_data            : upstream payload
//   out_valid/out_ready: downstream handshake
//   out_data           : main entry payload, zero whenever out_valid is low
//   stall_cnt          : cycles with out_valid && !out_ready, saturating
//                        (present only when PIPE_STALL_CNT_EN is defined)
// Because in_ready comes straight from the skid-valid flop, downstream back-pressure
// never reaches upstream through combinational logic.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = PIPE_PAYLOAD_W,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt
`endif
);

  skid_state_e          state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic [PAYLOAD_W-1:0] skid_q, skid_d;
  logic                 acc;
  logic                 drn;

  assign out_valid = state_q[1];
  assign in_ready  = ~state_q[0];
  // Every path that leaves main empty also zeroes it, so bubbles carry zero payload.
  assign out_data  = main_q;

  assign acc = in_valid && in_ready;
  assign drn = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // Offered entry is discarded; a drain this cycle has already been consumed downstream.
      state_d = StEmpty;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (acc) begin
            state_d = StOne;
            main_d  = in_data;
          end
        end
        StOne: begin
          if (acc && drn) begin
            main_d = in_data;
          end else if (acc) begin
            state_d = StFull;
            skid_d  = in_data;
          end else if (drn) begin
            state_d = StEmpty;
            main_d  = '0;
          end
        end
        StFull: begin
          // in_ready is low here, so only a drain can move the state.
          if (drn) begin
            state_d = StOne;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = StEmpty;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  pipe_sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .Clk     (Clk),
    .Reset_N (Reset_N),
    .en      (out_valid && !out_ready),
    .cnt     (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vector table, stall-counter
// sequence (when PIPE_STALL_CNT_EN is defined) and a queue-model ordering stream.
module tb_pipe_stage_skid;
  import pipe_stage_skid_pkg::*;

  localparam int unsigned W = PIPE_PAYLOAD_W;

  logic         Clk;
  logic         Reset_N;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  int checks = 0;
  int errors = 0;

`ifdef PIPE_STALL_CNT_EN
  logic [3:0] stall_cnt;
  pipe_stage_skid #(
    .PAYLOAD_W (W),
    .CNT_W     (4)
  ) dut (
    .Clk       (Clk),
    .Reset_N   (Reset_N),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );
`else
  pipe_stage_skid #(
    .PAYLOAD_W (W)
  ) dut (
    .Clk       (Clk),
    .Reset_N   (Reset_N),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );
`endif

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst_n;
    logic        fl;
    logic        iv;
    logic [15:0] din;
    logic        ordy;
    logic        exp_ov;
    logic        exp_ir;
    logic [15:0] exp_od;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [W-1:0] ext(input logic [15:0] v);
    return {{(W - 16){1'b0}}, v};
  endfunction

  task automatic add(input logic rst_n, input logic fl, input logic iv, input logic [15:0] din,
                     input logic ordy, input logic eov, input logic eir, input logic [15:0] eod);
    vec_t v;
    v.rst_n  = rst_n;
    v.fl     = fl;
    v.iv     = iv;
    v.din    = din;
    v.ordy   = ordy;
    v.exp_ov = eov;
    v.exp_ir = eir;
    v.exp_od = eod;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // (main_valid=0, skid_valid=1) shows up as out_valid=0 with in_ready=0.
  task automatic chk_legal(input int idx);
    chk("legal_state", idx, {63'd0, (!out_valid && !in_ready)}, 64'd0);
  endtask

  task automatic drive(input logic rst_n, input logic fl, input logic iv, input logic [15:0] din,
                       input logic ordy);
    Reset_N   = rst_n;
    flush     = fl;
    in_valid  = iv;
    in_data   = ext(din);
    out_ready = ordy;
  endtask

  logic [15:0] model_q[$];
  logic [15:0] exp_v;
  int unsigned next_val;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

    //   rst fl iv din       or  ov ir od
    // reset, including an offer that reset must ignore
    add(0, 0, 0, 16'h0000, 0, 0, 1, 16'h0000);
    add(0, 0, 1, 16'h00EE, 1, 0, 1, 16'h0000);
    // streaming at full rate
    add(1, 0, 1, 16'h0001, 1, 1, 1, 16'h0001);
    add(1, 0, 1, 16'h0002, 1, 1, 1, 16'h0002);
    add(1, 0, 1, 16'h0003, 1, 1, 1, 16'h0003);
    add(1, 0, 0, 16'h00DD, 1, 0, 1, 16'h0000);
    // back-pressure: fill to FULL, hold, then drain in order
    add(1, 0, 1, 16'h0011, 0, 1, 1, 16'h0011);
    add(1, 0, 1, 16'h0022, 0, 1, 0, 16'h0011);
    add(1, 0, 1, 16'h0099, 0, 1, 0, 16'h0011);
    add(1, 0, 0, 16'h0000, 1, 1, 1, 16'h0022);
    add(1, 0, 0, 16'h0000, 1, 0, 1, 16'h0000);
    // simultaneous accept and drain in ONE
    add(1, 0, 1, 16'h0033, 0, 1, 1, 16'h0033);
    add(1, 0, 1, 16'h0044, 1, 1, 1, 16'h0044);
    add(1, 0, 0, 16'h0000, 0, 1, 1, 16'h0044);
    add(1, 0, 0, 16'h0000, 1, 0, 1, 16'h0000);
    // flush in FULL with an offer pending; 0x77 must never appear
    add(1, 0, 1, 16'h0055, 0, 1, 1, 16'h0055);
    add(1, 0, 1, 16'h0066, 0, 1, 0, 16'h0055);
    add(1, 1, 1, 16'h0077, 0, 0, 1, 16'h0000);
    add(1, 0, 0, 16'h0000, 1, 0, 1, 16'h0000);
    // flush in ONE with in_ready=1 and a drain: offer 0x99 discarded
    add(1, 0, 1, 16'h0088, 0, 1, 1, 16'h0088);
    add(1, 1, 1, 16'h0099, 1, 0, 1, 16'h0000);
    add(1, 0, 0, 16'h0000, 1, 0, 1, 16'h0000);
    // reset during FULL with flush asserted
    add(1, 0, 1, 16'h00AA, 0, 1, 1, 16'h00AA);
    add(1, 0, 1, 16'h00BB, 0, 1, 0, 16'h00AA);
    add(0, 1, 1, 16'h00CC, 0, 0, 1, 16'h0000);
    add(1, 0, 0, 16'h0000, 1, 0, 1, 16'h0000);
    // FULL drains while upstream keeps offering; offer taken only once in_ready is back
    add(1, 0, 1, 16'h0012, 0, 1, 1, 16'h0012);
    add(1, 0, 1, 16'h0034, 0, 1, 0, 16'h0012);
    add(1, 0, 1, 16'h0056, 1, 1, 1, 16'h0034);
    add(1, 0, 1, 16'h0056, 1, 1, 1, 16'h0056);
    add(1, 0, 0, 16'h0000, 1, 0, 1, 16'h0000);

    foreach (vecs[i]) begin
      @(negedge Clk);
      drive(vecs[i].rst_n, vecs[i].fl, vecs[i].iv, vecs[i].din, vecs[i].ordy);
      @(posedge Clk);
      #1;
      chk("out_valid", i, {63'd0, out_valid}, {63'd0, vecs[i].exp_ov});
      chk("in_ready", i, {63'd0, in_ready}, {63'd0, vecs[i].exp_ir});
      chk("out_data", i, 64'(out_data), 64'(ext(vecs[i].exp_od)));
      chk_legal(i);
    end

`ifdef PIPE_STALL_CNT_EN
    // Stall counter: 10 stalled cycles, then saturation at 15, flush keeps it, reset clears it.
    @(negedge Clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge Clk);
    chk("stall_cnt_reset", 0, 64'(stall_cnt), 64'd0);
    drive(1'b1, 1'b0, 1'b1, 16'h0042, 1'b0);
    @(negedge Clk);
    chk("stall_cnt_first", 0, 64'(stall_cnt), 64'd0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    repeat (10) @(negedge Clk);
    chk("stall_cnt_10", 0, 64'(stall_cnt), 64'd10);
    repeat (10) @(negedge Clk);
    chk("stall_cnt_sat", 0, 64'(stall_cnt), 64'd15);
    chk("stall_out_data", 0, 64'(out_data), 64'(ext(16'h0042)));
    drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    @(negedge Clk);
    chk("stall_cnt_flush", 0, 64'(stall_cnt), 64'd15);
    chk("stall_flush_ov", 0, {63'd0, out_valid}, 64'd0);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    @(negedge Clk);
    chk("stall_cnt_rst", 0, 64'(stall_cnt), 64'd0);
`endif

    // Ordering stream against a queue model with random back-pressure.
    @(negedge Clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge Clk);
    next_val = 1;
    for (int c = 0; c < 320; c++) begin
      if (c < 300) begin
        drive(1'b1, 1'b0, ($urandom_range(0, 3) != 0), next_val[15:0],
              logic'($urandom_range(0, 1)));
      end else begin
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
      end
      if (!out_valid) chk("bubble_zero", c, 64'(out_data), 64'd0);
      if (out_valid && out_ready) begin
        if (model_q.size() == 0) begin
          chk("stream_spurious", c, 64'd1, 64'd0);
        end else begin
          exp_v = model_q.pop_front();
          chk("stream_order", c, 64'(out_data), 64'(ext(exp_v)));
        end
      end
      if (in_valid && in_ready) begin
        model_q.push_back(next_val[15:0]);
        next_val++;
      end
      chk_legal(c);
      @(negedge Clk);
    end
    chk("stream_drained", 0, 64'(model_q.size()), 64'd0);
    chk("stream_end_valid", 0, {63'd0, out_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
